// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST accelerator front end.
//   N_PIX      : pixels per 28x28 image
//   N_CLASSES  : number of output classes
//   PIX_W/D_W  : input pixel width / signed layer data width
//   FRAC_SHIFT : pixel-to-Q0.15 shift
//   TIMEOUT    : maximum cycles to wait for the layer
//   NO_RESULT  : class code returned when the layer never finishes
package mnist_pkg;

  localparam int unsigned N_PIX      = 784;
  localparam int unsigned N_CLASSES  = 10;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned D_W        = 16;
  localparam int unsigned FRAC_SHIFT = 7;
  localparam int unsigned TIMEOUT    = 4096;

  localparam logic [3:0] NO_RESULT = 4'hF;

  typedef enum logic [1:0] {
    StLoad,
    StStream,
    StWaitDone,
    StResult
  } streamer_state_t;

endpackage

// File: rtl/pix_buffer.sv
// Frame buffer: one write port, one read port, registered read (1-cycle latency).
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address, data appears on rdata_o after the next rising edge
//   rdata_o : read data
module pix_buffer #(
  parameter int unsigned Depth = 784,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_streamer.sv
// MNIST front end: buffers one image from a pixel stream, replays it one pixel per cycle
// into the output layer as Q0.15 data, then returns the layer's argmax as a result.
//   clk, rst              : clock, synchronous active-high reset
//   pix_valid/pix_ready   : upstream pixel handshake, pix_data in raster order
//   start, d_in           : layer start pulse (with first pixel) and signed pixel data
//   prediction/layer_done : layer argmax and completion level
//   res_valid/res_ready   : result handshake, res_class is the captured class
//   busy                  : high whenever not accepting pixels
//   err_timeout           : sticky, set when the layer never completes
module pixel_streamer #(
  parameter int unsigned N_PIX      = mnist_pkg::N_PIX,
  parameter int unsigned PIX_W      = mnist_pkg::PIX_W,
  parameter int unsigned D_W        = mnist_pkg::D_W,
  parameter int unsigned FRAC_SHIFT = mnist_pkg::FRAC_SHIFT,
  parameter int unsigned TIMEOUT    = mnist_pkg::TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             start,
  output logic [D_W-1:0]   d_in,
  input  logic [3:0]       prediction,
  input  logic             layer_done,
  output logic             res_valid,
  output logic [3:0]       res_class,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_timeout
);

  import mnist_pkg::*;

  localparam int unsigned CntW = $clog2(N_PIX);
  localparam int unsigned TimW = $clog2(TIMEOUT + 1);

  // The shifted pixel must stay clear of the sign bit.
  if (FRAC_SHIFT + PIX_W > D_W - 1) begin : g_width_check
    $error("pixel_streamer: FRAC_SHIFT + PIX_W exceeds D_W - 1");
  end

  streamer_state_t state_q, state_d;

  logic [CntW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [TimW-1:0]  to_cnt_q, to_cnt_d;
  logic             seen_low_q, seen_low_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_class_q, res_class_d;
  logic             err_q, err_d;

  logic             wr_en;
  logic [CntW-1:0]  rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [D_W-1:0]   pix_ext;

  pix_buffer #(
    .Depth (N_PIX),
    .Width (PIX_W),
    .AddrW (CntW)
  ) u_pix_buffer (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_cnt_q),
    .wdata_i (pix_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign pix_ext = D_W'(rd_data);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    to_cnt_d    = to_cnt_q;
    seen_low_d  = seen_low_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    rd_addr     = '0;
    pix_ready   = 1'b0;
    start       = 1'b0;
    d_in        = '0;

    unique case (state_q)
      StLoad: begin
        pix_ready  = 1'b1;
        seen_low_d = 1'b0;
        // rd_addr stays 0 here so mem[0] is already on rd_data in the first STREAM cycle.
        if (pix_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == CntW'(N_PIX - 1)) begin
            wr_cnt_d = '0;
            state_d  = StStream;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      StStream: begin
        d_in  = pix_ext << FRAC_SHIFT;
        start = (rd_cnt_q == '0);
        if (!layer_done) begin
          seen_low_d = 1'b1;
        end
        if (rd_cnt_q == CntW'(N_PIX - 1)) begin
          rd_cnt_d = '0;
          state_d  = StWaitDone;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          rd_addr  = rd_cnt_q + 1'b1;
        end
      end

      StWaitDone: begin
        if (!layer_done) begin
          seen_low_d = 1'b1;
        end
        // A qualified done takes priority over a timeout expiring in the same cycle.
        if (layer_done && seen_low_q) begin
          res_class_d = prediction;
          res_valid_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = StResult;
        end else if (to_cnt_q == TimW'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          res_class_d = NO_RESULT;
          res_valid_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = StResult;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StLoad;
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      to_cnt_q    <= '0;
      seen_low_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      to_cnt_q    <= to_cnt_d;
      seen_low_q  <= seen_low_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      err_q       <= err_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != StLoad);

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: nominal frame, bubbles/back-pressure, stale done,
// done-vs-timeout tie, timeout, back-to-back extremes, reset mid-stream.
module tb_pixel_streamer;

  localparam int N  = 784;
  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_ready;
  logic        start;
  logic [15:0] d_in;
  logic [3:0]  prediction = 4'h0;
  logic        layer_done = 1'b0;
  logic        res_valid;
  logic [3:0]  res_class;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_streamer #(
    .N_PIX      (N),
    .PIX_W      (8),
    .D_W        (16),
    .FRAC_SHIFT (7),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .start       (start),
    .d_in        (d_in),
    .prediction  (prediction),
    .layer_done  (layer_done),
    .res_valid   (res_valid),
    .res_class   (res_class),
    .res_ready   (res_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // mode 0: k mod 256, mode 1: all 255, mode 2: all 0
  function automatic int pix_of(input int mode, input int k);
    if (mode == 0) return k % 256;
    if (mode == 1) return 255;
    return 0;
  endfunction

  function automatic logic [15:0] exp_d(input int mode, input int k);
    return 16'(pix_of(mode, k) * 128);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the first STREAM cycle.
  task automatic load_frame(input int mode, input bit bubbles, input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      if (bubbles && ($urandom_range(1) == 1)) begin
        pix_valid = 1'b0;
        pix_data  = 8'h55;
        if (pix_ready !== 1'b1 || start !== 1'b0) bad++;
        @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_data  = 8'(pix_of(mode, i));
      if (pix_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || d_in !== 16'h0) bad++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk({tag, "_load"}, bad, 0);
    chk({tag, "_start_latency"}, start, 1);
  endtask

  // Full run returns at the negedge of the first WAIT_DONE cycle; stop_at >= 0 breaks there.
  task automatic stream_frame(input int mode, input int stop_at, input bit junk,
                              input string tag);
    int bad    = 0;
    int starts = 0;
    int first  = -1;
    for (int k = 0; k < N; k++) begin
      if (junk) begin
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
      end
      if (d_in !== exp_d(mode, k) || start !== (k == 0)) begin
        if (first < 0) first = k;
        bad++;
      end
      if (start === 1'b1) starts++;
      if (pix_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) bad++;
      if (k == stop_at) break;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    if (first >= 0) $display("stream %s first bad index %0d", tag, first);
    chk({tag, "_stream"}, bad, 0);
    chk({tag, "_starts"}, starts, 1);
  endtask

  // Checks the idle WAIT_DONE outputs at the current and the next n negedges.
  task automatic wait_idle(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i <= n; i++) begin
      if (res_valid !== 1'b0 || d_in !== 16'h0 || busy !== 1'b1 || pix_ready !== 1'b0) bad++;
      if (i < n) @(negedge clk);
    end
    chk({tag, "_idle"}, bad, 0);
  endtask

  task automatic consume(input logic [3:0] cls, input logic err, input string tag);
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_class"}, res_class, cls);
    chk({tag, "_err"}, err_timeout, err);
    chk({tag, "_ready_low"}, pix_ready, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_res_drop"}, res_valid, 0);
    chk({tag, "_ready_back"}, pix_ready, 1);
    chk({tag, "_err_hold"}, err_timeout, err);
  endtask

  initial begin
    int bad;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_d_in", d_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // A: nominal frame, done 20 cycles after the last pixel
    layer_done = 1'b0;
    load_frame(0, 1'b0, "a");
    stream_frame(0, -1, 1'b0, "a");
    wait_idle(19, "a");
    layer_done = 1'b1;
    prediction = 4'd7;
    @(negedge clk);
    consume(4'd7, 1'b0, "a");

    // B: upstream bubbles, ignored pix_valid while streaming, result back-pressure
    layer_done = 1'b0;
    prediction = 4'd0;
    load_frame(0, 1'b1, "b");
    stream_frame(0, -1, 1'b1, "b");
    wait_idle(2, "b");
    layer_done = 1'b1;
    prediction = 4'd2;
    @(negedge clk);
    prediction = 4'd6;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || res_class !== 4'd2 || pix_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("b_hold", bad, 0);
    consume(4'd2, 1'b0, "b");

    // C: stale done high through the stream and the first WAIT_DONE cycle
    layer_done = 1'b1;
    prediction = 4'd5;
    load_frame(0, 1'b0, "c");
    stream_frame(0, -1, 1'b0, "c");
    @(negedge clk);
    chk("c_stale_ignored", res_valid, 0);
    layer_done = 1'b0;
    wait_idle(5, "c");
    layer_done = 1'b1;
    prediction = 4'd4;
    @(negedge clk);
    consume(4'd4, 1'b0, "c");

    // D: done qualifies in the cycle the timeout expires; done wins
    layer_done = 1'b0;
    load_frame(0, 1'b0, "d");
    stream_frame(0, -1, 1'b0, "d");
    wait_idle(TO - 1, "d");
    layer_done = 1'b1;
    prediction = 4'd3;
    @(negedge clk);
    consume(4'd3, 1'b0, "d");

    // E: layer never completes
    layer_done = 1'b0;
    load_frame(0, 1'b0, "e");
    stream_frame(0, -1, 1'b0, "e");
    wait_idle(TO - 1, "e");
    @(negedge clk);
    consume(4'hF, 1'b1, "e");

    // F: all-255 then all-0 back to back; error flag stays set
    load_frame(1, 1'b0, "f1");
    stream_frame(1, -1, 1'b0, "f1");
    layer_done = 1'b1;
    prediction = 4'd1;
    @(negedge clk);
    consume(4'd1, 1'b1, "f1");
    layer_done = 1'b0;
    load_frame(2, 1'b0, "f2");
    stream_frame(2, -1, 1'b0, "f2");
    layer_done = 1'b1;
    prediction = 4'd0;
    @(negedge clk);
    consume(4'd0, 1'b1, "f2");

    // G: reset at stream index 300
    layer_done = 1'b0;
    load_frame(0, 1'b0, "g");
    stream_frame(0, 300, 1'b0, "g");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("g_d_in", d_in, 0);
    chk("g_start", start, 0);
    chk("g_pix_ready", pix_ready, 1);
    chk("g_busy", busy, 0);
    chk("g_err_cleared", err_timeout, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (start !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("g_no_start", bad, 0);

    // H: fresh frame after the abandoned one
    load_frame(0, 1'b0, "h");
    stream_frame(0, -1, 1'b0, "h");
    layer_done = 1'b1;
    prediction = 4'd8;
    @(negedge clk);
    consume(4'd8, 1'b0, "h");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
